// File: rtl/id_ex_stage_if.sv
// ID <-> ID/EX register signal bundle; the ID side is master and the stage is slave.
// ID_EX_PERF_EN adds the perf_bubble_o / perf_stall_o counter outputs.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 8
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [DATA_W-1:0] pc_i;
  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic [ADDR_W-1:0] RDaddr_i;
  logic [15:0]       imm_i;
  logic [DATA_W-1:0] RSdata_i;
  logic [DATA_W-1:0] RTdata_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [ADDR_W-1:0] WBaddr_i;
  logic [DATA_W-1:0] WBdata_i;
  logic              WBwrite_i;

  logic              valid_o;
  logic [DATA_W-1:0] pc_o;
  logic [ADDR_W-1:0] RSaddr_o;
  logic [ADDR_W-1:0] RTaddr_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] imm_o;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic              load_use_o;
`ifdef ID_EX_PERF_EN
  logic [31:0]       perf_bubble_o;
  logic [31:0]       perf_stall_o;
`endif

  modport master (
    output stall_i, flush_i, valid_i, pc_i, RSaddr_i, RTaddr_i, RDaddr_i, imm_i,
           RSdata_i, RTdata_i, ctrl_i, WBaddr_i, WBdata_i, WBwrite_i,
    input  valid_o, pc_o, RSaddr_o, RTaddr_o, RDaddr_o, imm_o, RSdata_o, RTdata_o,
           ctrl_o, load_use_o
`ifdef ID_EX_PERF_EN
           , perf_bubble_o, perf_stall_o
`endif
  );

  modport slave (
    input  stall_i, flush_i, valid_i, pc_i, RSaddr_i, RTaddr_i, RDaddr_i, imm_i,
           RSdata_i, RTdata_i, ctrl_i, WBaddr_i, WBdata_i, WBwrite_i,
    output valid_o, pc_o, RSaddr_o, RTaddr_o, RDaddr_o, imm_o, RSdata_o, RTdata_o,
           ctrl_o, load_use_o
`ifdef ID_EX_PERF_EN
           , perf_bubble_o, perf_stall_o
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubbles, stall (hold) and flush.
// Latency 1 cycle; stall_i holds contents, load_use_o asks ID/IF to hold. ID_EX_PERF_EN adds counters.
module id_ex_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int CTRL_W      = 8,
  parameter int MEMREAD_BIT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs_dat;
    logic [DATA_W-1:0] rt_dat;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t  ex_q;
  ex_t  ex_ld;
  logic load_use;
  logic bubble_ld;
  logic hold_rs;
  logic hold_rt;

  assign load_use = ex_q.valid & ex_q.ctrl[MEMREAD_BIT] & bus.valid_i
                  & (ex_q.rt != {ADDR_W{1'b0}})
                  & ((ex_q.rt == bus.RSaddr_i) | (ex_q.rt == bus.RTaddr_i));

  // Flush beats stall; a hazard or empty ID slot only bubbles when not stalled.
  assign bubble_ld = bus.flush_i | (~bus.stall_i & (load_use | ~bus.valid_i));

  assign hold_rs = ex_q.valid & bus.WBwrite_i & (bus.WBaddr_i != {ADDR_W{1'b0}})
                 & (bus.WBaddr_i == ex_q.rs);
  assign hold_rt = ex_q.valid & bus.WBwrite_i & (bus.WBaddr_i != {ADDR_W{1'b0}})
                 & (bus.WBaddr_i == ex_q.rt);

  always_comb begin
    ex_ld        = '0;
    ex_ld.valid  = 1'b1;
    ex_ld.pc     = bus.pc_i;
    ex_ld.rs     = bus.RSaddr_i;
    ex_ld.rt     = bus.RTaddr_i;
    ex_ld.rd     = bus.RDaddr_i;
    ex_ld.imm    = {{(DATA_W-16){bus.imm_i[15]}}, bus.imm_i};
    ex_ld.ctrl   = bus.ctrl_i;
    ex_ld.rs_dat = bus.RSdata_i;
    ex_ld.rt_dat = bus.RTdata_i;
    // The register file reads the old value during a same-cycle write, so forward it here.
    if (bus.RSaddr_i == {ADDR_W{1'b0}})
      ex_ld.rs_dat = '0;
    else if (bus.WBwrite_i && (bus.WBaddr_i == bus.RSaddr_i))
      ex_ld.rs_dat = bus.WBdata_i;
    if (bus.RTaddr_i == {ADDR_W{1'b0}})
      ex_ld.rt_dat = '0;
    else if (bus.WBwrite_i && (bus.WBaddr_i == bus.RTaddr_i))
      ex_ld.rt_dat = bus.WBdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_ld) begin
      ex_q <= '0;
    end else if (bus.stall_i) begin
      // Held operands keep tracking write-back so they are not stale on release.
      if (hold_rs) ex_q.rs_dat <= bus.WBdata_i;
      if (hold_rt) ex_q.rt_dat <= bus.WBdata_i;
    end else begin
      ex_q <= ex_ld;
    end
  end

  assign bus.valid_o    = ex_q.valid;
  assign bus.pc_o       = ex_q.pc;
  assign bus.RSaddr_o   = ex_q.rs;
  assign bus.RTaddr_o   = ex_q.rt;
  assign bus.RDaddr_o   = ex_q.rd;
  assign bus.imm_o      = ex_q.imm;
  assign bus.RSdata_o   = ex_q.rs_dat;
  assign bus.RTdata_o   = ex_q.rt_dat;
  assign bus.ctrl_o     = ex_q.ctrl;
  assign bus.load_use_o = load_use;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_bubble_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (bus.flush_i | (~bus.stall_i & load_use)) perf_bubble_q <= perf_bubble_q + 32'd1;
      if (bus.stall_i & ~bus.flush_i)              perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_bubble_o = perf_bubble_q;
  assign bus.perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then random traffic vs. a reference model.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, rsd, rtd;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t        m;
  exp_t        nx;
  logic [31:0] pb, ps, pb_nx, ps_nx, pb_save, ps_save;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (bus.WBwrite_i && bus.WBaddr_i == a) return bus.WBdata_i;
    return rf;
  endfunction

  function automatic logic exp_lu();
    return m.v && m.ctrl[1] && bus.valid_i && (m.rt != 5'd0)
           && (m.rt == bus.RSaddr_i || m.rt == bus.RTaddr_i);
  endfunction

  task automatic check_outs();
    chk_eq("valid_o",  bus.valid_o,  m.v);
    chk_eq("pc_o",     bus.pc_o,     m.pc);
    chk_eq("RSaddr_o", bus.RSaddr_o, m.rs);
    chk_eq("RTaddr_o", bus.RTaddr_o, m.rt);
    chk_eq("RDaddr_o", bus.RDaddr_o, m.rd);
    chk_eq("imm_o",    bus.imm_o,    m.imm);
    chk_eq("RSdata_o", bus.RSdata_o, m.rsd);
    chk_eq("RTdata_o", bus.RTdata_o, m.rtd);
    chk_eq("ctrl_o",   bus.ctrl_o,   m.ctrl);
`ifdef ID_EX_PERF_EN
    chk_eq("perf_bubble_o", bus.perf_bubble_o, pb);
    chk_eq("perf_stall_o",  bus.perf_stall_o,  ps);
`endif
  endtask

  // Inputs are already applied; check the hazard output, predict and check the next edge.
  task automatic step();
    logic lu;
    #1;
    lu = exp_lu();
    chk_eq("load_use_o", bus.load_use_o, lu);
    nx = m;
    if (rst || bus.flush_i) begin
      nx = '0;
    end else if (bus.stall_i) begin
      if (m.v && bus.WBwrite_i && bus.WBaddr_i != 5'd0) begin
        if (bus.WBaddr_i == m.rs) nx.rsd = bus.WBdata_i;
        if (bus.WBaddr_i == m.rt) nx.rtd = bus.WBdata_i;
      end
    end else if (lu || !bus.valid_i) begin
      nx = '0;
    end else begin
      nx.v    = 1'b1;
      nx.pc   = bus.pc_i;
      nx.rs   = bus.RSaddr_i;
      nx.rt   = bus.RTaddr_i;
      nx.rd   = bus.RDaddr_i;
      nx.imm  = {{16{bus.imm_i[15]}}, bus.imm_i};
      nx.rsd  = opnd(bus.RSaddr_i, bus.RSdata_i);
      nx.rtd  = opnd(bus.RTaddr_i, bus.RTdata_i);
      nx.ctrl = bus.ctrl_i;
    end
    if (rst) begin
      pb_nx = 0;
      ps_nx = 0;
    end else begin
      pb_nx = pb + ((bus.flush_i || (!bus.stall_i && lu)) ? 32'd1 : 32'd0);
      ps_nx = ps + ((bus.stall_i && !bus.flush_i) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    m  = nx;
    pb = pb_nx;
    ps = ps_nx;
    check_outs();
  endtask

  task automatic idle();
    rst = 1'b0;
    bus.stall_i = 0; bus.flush_i = 0; bus.valid_i = 0; bus.pc_i = 0;
    bus.RSaddr_i = 0; bus.RTaddr_i = 0; bus.RDaddr_i = 0; bus.imm_i = 0;
    bus.RSdata_i = 0; bus.RTdata_i = 0; bus.ctrl_i = 0;
    bus.WBaddr_i = 0; bus.WBdata_i = 0; bus.WBwrite_i = 0;
  endtask

  task automatic rnd_in();
    rst          = ($urandom_range(0, 99) < 3);
    bus.stall_i  = ($urandom_range(0, 99) < 20);
    bus.flush_i  = ($urandom_range(0, 99) < 8);
    bus.valid_i  = ($urandom_range(0, 99) < 85);
    bus.pc_i     = $urandom;
    bus.RSaddr_i = 5'($urandom_range(0, 7));
    bus.RTaddr_i = 5'($urandom_range(0, 7));
    bus.RDaddr_i = 5'($urandom);
    bus.imm_i    = 16'($urandom);
    bus.RSdata_i = $urandom;
    bus.RTdata_i = $urandom;
    bus.ctrl_i   = 8'($urandom);
    bus.WBaddr_i = 5'($urandom_range(0, 7));
    bus.WBdata_i = $urandom;
    bus.WBwrite_i = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input nonzero.
    rst = 1'b1;
    bus.stall_i = 1; bus.flush_i = 1; bus.valid_i = 1; bus.pc_i = 32'hDEADBEEF;
    bus.RSaddr_i = 5'h1F; bus.RTaddr_i = 5'h1E; bus.RDaddr_i = 5'h1D; bus.imm_i = 16'hFFFF;
    bus.RSdata_i = 32'h1111; bus.RTdata_i = 32'h2222; bus.ctrl_i = 8'hFF;
    bus.WBaddr_i = 5'h1F; bus.WBdata_i = 32'h3333; bus.WBwrite_i = 1;
    m = '0; pb = 0; ps = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    chk_eq("reset_load_use", bus.load_use_o, 1'b0);

    // Pass-through with sign extension.
    idle();
    bus.valid_i = 1; bus.pc_i = 32'h40; bus.imm_i = 16'hFFFE;
    bus.RSaddr_i = 5'd2; bus.RSdata_i = 32'd5;
    step();
    chk_eq("pass_valid", bus.valid_o, 1'b1);
    chk_eq("pass_pc", bus.pc_o, 32'h40);
    chk_eq("pass_imm", bus.imm_o, 32'hFFFF_FFFE);
    chk_eq("pass_rs", bus.RSdata_o, 32'd5);

    // Same-cycle write-back bypass, and r0 never bypassed.
    bus.RSaddr_i = 5'd3; bus.RSdata_i = 32'd1;
    bus.WBwrite_i = 1; bus.WBaddr_i = 5'd3; bus.WBdata_i = 32'hAA;
    step();
    chk_eq("bypass_rs", bus.RSdata_o, 32'hAA);
    bus.RSaddr_i = 5'd0; bus.WBaddr_i = 5'd0;
    step();
    chk_eq("bypass_r0", bus.RSdata_o, 32'd0);

    // Load-use: lw with rt=8 in EX, consumer reads r8.
    idle();
    bus.valid_i = 1; bus.ctrl_i = 8'h02; bus.RTaddr_i = 5'd8; bus.RSaddr_i = 5'd1;
    step();
    bus.ctrl_i = 8'h00; bus.RSaddr_i = 5'd8; bus.RTaddr_i = 5'd9; bus.pc_i = 32'h80;
    #1;
    chk_eq("lu_asserted", bus.load_use_o, 1'b1);
    step();
    chk_eq("lu_bubble_valid", bus.valid_o, 1'b0);
    chk_eq("lu_bubble_ctrl", bus.ctrl_o, 8'h00);
    step();
    chk_eq("lu_reenter_valid", bus.valid_o, 1'b1);
    chk_eq("lu_reenter_rs", bus.RSaddr_o, 5'd8);

    // Stall three cycles with a write-back to the held rt in the middle one.
    idle();
    bus.valid_i = 1; bus.pc_i = 32'h100; bus.RTaddr_i = 5'd7; bus.RTdata_i = 32'h11;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.stall_i = 1; bus.pc_i = 32'h999 + i; bus.RTaddr_i = 5'd3;
      bus.WBwrite_i = (i == 1); bus.WBaddr_i = 5'd7; bus.WBdata_i = 32'h55;
      step();
    end
    chk_eq("stall_rt_bypass", bus.RTdata_o, 32'h55);
    chk_eq("stall_pc_hold", bus.pc_o, 32'h100);
    chk_eq("stall_rt_hold", bus.RTaddr_o, 5'd7);

    // Flush wins over stall.
    pb_save = pb; ps_save = ps;
    bus.WBwrite_i = 0; bus.flush_i = 1; bus.stall_i = 1;
    step();
    chk_eq("flush_valid", bus.valid_o, 1'b0);
`ifdef ID_EX_PERF_EN
    chk_eq("flush_perf_bubble", bus.perf_bubble_o, pb_save + 32'd1);
    chk_eq("flush_perf_stall", bus.perf_stall_o, ps_save);
`endif

    // Reset in the middle of a stall.
    idle();
    bus.valid_i = 1; bus.pc_i = 32'h200;
    step();
    bus.stall_i = 1; rst = 1;
    step();
    chk_eq("rst_mid_stall", bus.valid_o, 1'b0);

    for (int i = 0; i < 600; i++) begin
      rnd_in();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
